pixel_group_arbiter: RTL

PIXEL_GROUP_ARBITER -- requirements
Module: pixel_group_arbiter

---
 rtl/pixel_group_arbiter_if.sv | 26 ++
 rtl/pixel_group_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_group_arbiter_if.sv
// Request/event bus between a pixel array, the group arbiter and the event consumer.
// master: arbiter side (drives events and grants); slave: array/consumer side.
interface pixel_group_arbiter_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int POL_W = 2,
  parameter int ADD_W = ($clog2(ROWS) > $clog2(COLS)) ? $clog2(ROWS) : $clog2(COLS)
);
  logic [ROWS-1:0][COLS-1:0][POL_W-1:0] req_i;
  logic                                 evt_ready_i;
  logic [ROWS-1:0][COLS-1:0]            gnt_o;
  logic                                 evt_valid_o;
  logic [ADD_W-1:0]                     x_add_o;
  logic [ADD_W-1:0]                     y_add_o;
  logic [POL_W-1:0]                     pol_o;

  modport master (
    input  req_i, evt_ready_i,
    output gnt_o, evt_valid_o, x_add_o, y_add_o, pol_o
  );

  modport slave (
    output req_i, evt_ready_i,
    input  gnt_o, evt_valid_o, x_add_o, y_add_o, pol_o
  );
endinterface

// File: rtl/pixel_group_arbiter.sv
// Row-major scanning arbiter for a pixel request array. One pass walks rows in
// ascending order, serves every requesting column of a row, and pulses
// grp_release_o once a pass that served something completes.
module pixel_group_arbiter #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int POL_W = 2,
  parameter int ADD_W = ($clog2(ROWS) > $clog2(COLS)) ? $clog2(ROWS) : $clog2(COLS)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  output logic active_o,
  output logic req_o,
  output logic grp_release_o,
  pixel_group_arbiter_if.master bus
);

  // Scan pointers carry one extra bit so the "past the last row/column"
  // value (ROWS or COLS) is representable and never aliases back to 0.
  localparam int PTR_W = ADD_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROW_SEL = 2'd1,
    COL_SEL = 2'd2,
    EMIT    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] cptr_q, cptr_d;
  logic             served_q, served_d;
  logic [ADD_W-1:0] x_q, x_d;
  logic [ADD_W-1:0] y_q, y_d;
  logic [POL_W-1:0] pol_q, pol_d;
  logic             grp_rel_q, grp_rel_d;

  logic             row_found_s;
  logic [ADD_W-1:0] row_idx_s;
  logic             col_found_s;
  logic [ADD_W-1:0] col_idx_s;
  logic             evt_valid_s;
  logic             handshake_s;
  logic [ROWS-1:0][COLS-1:0] gnt_s;

  assign evt_valid_s = (state_q == EMIT);
  assign handshake_s = evt_valid_s & bus.evt_ready_i;

  // Lowest requesting row at or above the row pointer.
  always_comb begin
    row_found_s = 1'b0;
    row_idx_s   = {ADD_W{1'b0}};
    for (int r = ROWS - 1; r >= 0; r--) begin
      row_idx_s   = ((PTR_W'(r) >= rptr_q) && (|bus.req_i[r])) ? ADD_W'(r) : row_idx_s;
      row_found_s = row_found_s | ((PTR_W'(r) >= rptr_q) && (|bus.req_i[r]));
    end
  end

  // Lowest requesting column at or above the column pointer in the latched row.
  always_comb begin
    col_found_s = 1'b0;
    col_idx_s   = {ADD_W{1'b0}};
    for (int c = COLS - 1; c >= 0; c--) begin
      col_idx_s   = ((PTR_W'(c) >= cptr_q) && (bus.req_i[x_q][c] != {POL_W{1'b0}})) ? ADD_W'(c) : col_idx_s;
      col_found_s = col_found_s | ((PTR_W'(c) >= cptr_q) && (bus.req_i[x_q][c] != {POL_W{1'b0}}));
    end
  end

  // Next-state and datapath updates of the scan FSM.
  always_comb begin
    state_d   = state_q;
    rptr_d    = rptr_q;
    cptr_d    = cptr_q;
    served_d  = served_q;
    x_d       = x_q;
    y_d       = y_q;
    pol_d     = pol_q;
    grp_rel_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = ROW_SEL;
          rptr_d  = {PTR_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ROW_SEL: begin
        if (!enable_i) begin
          state_d  = IDLE;
          rptr_d   = {PTR_W{1'b0}};
          cptr_d   = {PTR_W{1'b0}};
          served_d = 1'b0;
        end else if (row_found_s) begin
          state_d = COL_SEL;
          x_d     = row_idx_s;
          cptr_d  = {PTR_W{1'b0}};
        end else begin
          // End of pass: wrap and announce it only if something was served.
          rptr_d    = {PTR_W{1'b0}};
          grp_rel_d = served_q;
          served_d  = 1'b0;
        end
      end
      COL_SEL: begin
        if (!enable_i) begin
          state_d  = IDLE;
          rptr_d   = {PTR_W{1'b0}};
          cptr_d   = {PTR_W{1'b0}};
          served_d = 1'b0;
        end else if (col_found_s) begin
          state_d = EMIT;
          y_d     = col_idx_s;
          pol_d   = bus.req_i[x_q][col_idx_s];
        end else begin
          state_d = ROW_SEL;
          rptr_d  = {1'b0, x_q} + {{ADD_W{1'b0}}, 1'b1};
        end
      end
      EMIT: begin
        // The event is never dropped: only the handshake leaves this state.
        if (handshake_s) begin
          if (enable_i) begin
            state_d  = COL_SEL;
            served_d = 1'b1;
            cptr_d   = {1'b0, y_q} + {{ADD_W{1'b0}}, 1'b1};
          end else begin
            state_d  = IDLE;
            served_d = 1'b0;
            rptr_d   = {PTR_W{1'b0}};
            cptr_d   = {PTR_W{1'b0}};
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      rptr_q    <= {PTR_W{1'b0}};
      cptr_q    <= {PTR_W{1'b0}};
      served_q  <= 1'b0;
      x_q       <= {ADD_W{1'b0}};
      y_q       <= {ADD_W{1'b0}};
      pol_q     <= {POL_W{1'b0}};
      grp_rel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rptr_q    <= rptr_d;
      cptr_q    <= cptr_d;
      served_q  <= served_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pol_q     <= pol_d;
      grp_rel_q <= grp_rel_d;
    end
  end

  // One-hot grant, asserted only in the handshake cycle.
  always_comb begin
    gnt_s           = {(ROWS * COLS){1'b0}};
    gnt_s[x_q][y_q] = handshake_s;
  end

  assign bus.gnt_o       = gnt_s;
  assign bus.evt_valid_o = evt_valid_s;
  assign bus.x_add_o     = x_q;
  assign bus.y_add_o     = y_q;
  assign bus.pol_o       = pol_q;
  assign active_o        = (state_q == COL_SEL) || (state_q == EMIT);
  assign req_o           = |bus.req_i;
  assign grp_release_o   = grp_rel_q;

endmodule
